pmem_responder: RTL and testbench



---
 rtl/pmem_types.sv | 15 +
 rtl/pmem_line_array.sv | 26 ++
 rtl/pmem_responder.sv | 143 ++++++++++++++
 tb/tb_pmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pmem_types.sv
// Shared types and constants for the 256-bit line-granular pmem interface.
package pmem_types;

  localparam int unsigned PMEM_OFFSET_BITS = 5;
  localparam int unsigned PMEM_LINE_W      = 256;

  typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line storage: combinational read, clocked write, contents not reset.
module pmem_line_array
  import pmem_types::*;
#(
  parameter  int unsigned NUM_LINES = 256,
  localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output pmem_line_t       rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  pmem_line_t       wr_data
);

  pmem_line_t mem [NUM_LINES];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for the 256-bit pmem_* interface.
// Optional open-row fast path enabled by defining PMEM_OPEN_ROW_EN.
module pmem_responder
  import pmem_types::*;
#(
  parameter int unsigned NUM_LINES   = 256,
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned HIT_LATENCY = 3,
  parameter int unsigned ROW_LINES   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  pmem_line_t  pmem_wdata,
  output logic        pmem_resp,
  output pmem_line_t  pmem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  pmem_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  idx_t        idx_q, idx_d;
  pmem_line_t  wdata_q, wdata_d;
  pmem_line_t  rdata_d;
  logic        resp_d;

  logic        req;
  idx_t        req_idx;
  cnt_t        load_cnt;
  pmem_line_t  arr_rdata;
  logic        arr_we;
  logic        unused_ok;

  assign req     = pmem_read | pmem_write;
  assign req_idx = pmem_address[PMEM_OFFSET_BITS +: IDX_W];

  // Offset and wrap-around address bits are intentionally dropped.
  assign unused_ok = ^{pmem_address, 1'(HIT_LATENCY), 1'(ROW_LINES)};

`ifdef PMEM_OPEN_ROW_EN
  localparam int unsigned ROW_SHIFT = $clog2(ROW_LINES);

  idx_t row_q;
  logic row_vld_q;
  logic row_hit;

  assign row_hit  = row_vld_q && ((req_idx >> ROW_SHIFT) == row_q);
  assign load_cnt = row_hit ? CNT_W'(HIT_LATENCY - 1) : CNT_W'(LATENCY - 1);

  // Every accepted request opens its row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      row_vld_q <= 1'b0;
    end else if (state_q == IDLE && req) begin
      row_q     <= req_idx >> ROW_SHIFT;
      row_vld_q <= 1'b1;
    end
  end
`else
  assign load_cnt = CNT_W'(LATENCY - 1);
`endif

  pmem_line_array #(
    .NUM_LINES(NUM_LINES)
  ) u_array (
    .clk    (clk),
    .rd_idx (idx_q),
    .rd_data(arr_rdata),
    .we     (arr_we),
    .wr_idx (idx_q),
    .wr_data(wdata_q)
  );

  // Next-state and datapath: counter reaching 0 lands in RESP, read data captured on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = pmem_rdata;
    arr_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          op_wr_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = load_cnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
          if (!op_wr_q) begin
            rdata_d = arr_rdata;
          end
        end
      end
      RESP: begin
        arr_we  = op_wr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    resp_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      pmem_rdata <= '0;
      pmem_resp  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      pmem_rdata <= rdata_d;
      pmem_resp  <= resp_d;
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench for pmem_responder (default parameters).
module tb_pmem_responder;
  import pmem_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = '0;
  pmem_line_t  pmem_wdata = '0;
  logic        pmem_resp;
  pmem_line_t  pmem_rdata;

  int checks = 0;
  int failures = 0;

  localparam int EXP_LAT = 10;
`ifdef PMEM_OPEN_ROW_EN
  localparam int EXP_HIT = 3;
`else
  localparam int EXP_HIT = 10;
`endif

  localparam pmem_line_t L11 = {32{8'h11}};
  localparam pmem_line_t LAB = {32{8'hAB}};
  localparam pmem_line_t LCC = {32{8'hCC}};

  always #5 clk = ~clk;

  pmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count negedges until resp is seen; -1 when the bound expires.
  task automatic wait_resp(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (pmem_resp) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  task automatic count_resp(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (pmem_resp) cnt++;
    end
  endtask

  // Raise a request at a negedge, hold it through the RESP cycle's closing edge, then drop it.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input pmem_line_t wd, output int lat);
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    wait_resp(lat);
    @(posedge clk);
    #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    int lat;
    int n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    count_resp(20, n);
    check("idle_no_resp", 256'(n), 256'(0));
    check("reset_rdata", pmem_rdata, '0);

    access(1'b0, 1'b1, 32'h0000_0040, L11, lat);
    check("wr_latency", 256'(lat), 256'(EXP_LAT));
    count_resp(12, n);
    check("wr_single_resp", 256'(n), 256'(0));

    access(1'b1, 1'b0, 32'h0000_0040, '0, lat);
    check("rd_latency", 256'(lat), 256'(EXP_LAT));
    check("rd_data", pmem_rdata, L11);

    access(1'b1, 1'b0, 32'h0000_205F, '0, lat);
    check("alias_latency", 256'(lat), 256'(EXP_LAT));
    check("alias_data", pmem_rdata, L11);

    access(1'b1, 1'b1, 32'h0000_0060, LAB, lat);
    check("both_latency", 256'(lat), 256'(EXP_LAT));
    check("both_no_read", pmem_rdata, L11);

    // Back-to-back: request stays high through RESP, new read raised in the following IDLE cycle.
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_0040;
    wait_resp(lat);
    check("b2b_first_latency", 256'(lat), 256'(EXP_LAT));
    check("b2b_first_data", pmem_rdata, L11);
    @(posedge clk);
    #1;
    pmem_address = 32'h0000_0060;
    wait_resp(lat);
    check("b2b_second_latency", 256'(lat), 256'(EXP_LAT + 1));
    check("b2b_second_data", pmem_rdata, LAB);
    @(posedge clk);
    #1;
    pmem_read = 1'b0;
    count_resp(12, n);
    check("b2b_no_extra_resp", 256'(n), 256'(0));

    access(1'b1, 1'b0, 32'h0000_0100, '0, lat);
    check("row_miss_line8", 256'(lat), 256'(EXP_LAT));
    access(1'b1, 1'b0, 32'h0000_0120, '0, lat);
    check("row_hit_line9", 256'(lat), 256'(EXP_HIT));
    access(1'b1, 1'b0, 32'h0000_0800, '0, lat);
    check("row_miss_line64", 256'(lat), 256'(EXP_LAT));

    // Reset in the middle of a write: no resp, no commit.
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 32'h0000_0060;
    pmem_wdata   = LCC;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_resp", 256'(pmem_resp), 256'(0));
    check("midreset_rdata", pmem_rdata, '0);
    pmem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_resp(12, n);
    check("midreset_no_resp", 256'(n), 256'(0));

    access(1'b1, 1'b0, 32'h0000_0060, '0, lat);
    check("post_reset_latency", 256'(lat), 256'(EXP_LAT));
    check("post_reset_no_commit", pmem_rdata, LAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
